// File: rtl/resp_compactor_if.sv
// resp_compactor_if: run control, response stream and result signals of the compactor.
interface resp_compactor_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] length;
   logic [63:0]      expected;
   logic             resp_valid;
   logic [63:0]      resp_data;
   logic             resp_ready;
   logic             busy;
   logic             done;
   logic             pass;
   logic [63:0]      signature;
   modport master (
      output start, abort, length, expected, resp_valid, resp_data,
      input  resp_ready, busy, done, pass, signature
   );
   modport slave (
      input  start, abort, length, expected, resp_valid, resp_data,
      output resp_ready, busy, done, pass, signature
   );
endinterface

// File: rtl/resp_compactor.sv
// resp_compactor: folds response beats into a 64-bit signature and checks it against a golden value.
module resp_compactor #(
   parameter int CNT_W = 16
) (
   input logic             clk,
   input logic             rst_n,
   resp_compactor_if.slave b
);
   typedef enum logic [1:0] {IDLE, COMPACT, CHECK} state_t;
   localparam logic [63:0] SEED = 64'd1;
   // s[0] feeds back into bit 63 and the ring generator's tap positions
   localparam logic [63:0] FB = 64'h8010_0810_0810_2040;
   state_t           state_q, state_d;
   logic [63:0]      sig_q, sig_d, exp_q, exp_d, sig_nx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d, pass_q, pass_d;
   assign sig_nx = {1'b0, sig_q[63:1]} ^ (sig_q[0] ? FB : 64'd0) ^ b.resp_data;
   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (b.start) begin
            sig_d   = SEED;
            cnt_d   = b.length;
            exp_d   = b.expected;
            pass_d  = 1'b0;
            state_d = (b.length == '0) ? CHECK : COMPACT;
         end
         COMPACT: if (b.abort) begin
            pass_d  = 1'b0;
            state_d = IDLE;
         end else if (b.resp_valid) begin
            sig_d   = sig_nx;
            cnt_d   = cnt_q - CNT_W'(cnt_q != '0);
            state_d = (cnt_q == CNT_W'(1)) ? CHECK : COMPACT;
         end
         CHECK: begin
            pass_d  = b.abort ? 1'b0 : (sig_q == exp_q);
            done_d  = ~b.abort;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         exp_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end
   assign b.resp_ready = (state_q == COMPACT);
   assign b.busy       = (state_q != IDLE);
   assign b.done       = done_q;
   assign b.pass       = pass_q;
   assign b.signature  = sig_q;
endmodule

// File: tb/tb_resp_compactor.sv
// tb_resp_compactor: scoreboard bench; each completed run's expected signature/pass is queued
// by the driver and checked when done pulses.
module tb_resp_compactor;
   localparam logic [63:0] ONE_BEAT0 = 64'h8010_0810_0810_2040;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   resp_compactor_if #(.CNT_W(16)) b ();
   resp_compactor #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .b(b));
   typedef struct {
      logic [63:0] sig;
      logic        pass;
   } exp_t;
   exp_t        sb[$];
   exp_t        e;
   int          errors = 0;
   int          checks = 0;
   logic [63:0] data_a[8];
   bit          valid_a[16];
   logic [63:0] m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] step(input logic [63:0] s, input logic [63:0] d);
      int taps[7] = '{6, 13, 20, 27, 36, 43, 52};
      logic [63:0] n;
      for (int i = 0; i < 63; i++) n[i] = s[i+1] ^ d[i];
      n[63] = s[0] ^ d[63];
      foreach (taps[j]) n[taps[j]] = n[taps[j]] ^ s[0];
      return n;
   endfunction

   always @(negedge clk) begin
      if (rst_n && b.done) begin
         if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            check("sb_sig", b.signature, e.sig);
            check("sb_pass", 64'(b.pass), 64'(e.pass));
         end
      end
   end

   // Drives one run from IDLE; returns in the done cycle so a following call lands back-to-back.
   task automatic run(input int len, input logic [63:0] expv, input int nv, input bit hold,
                      input bit ab_start);
      logic [63:0] s = 64'd1;
      int acc = 0;
      b.start = 1'b1;
      b.length = 16'(len);
      b.expected = expv;
      b.abort = ab_start;
      @(negedge clk);
      b.start = hold;
      b.abort = 1'b0;
      check("run_busy", 64'(b.busy), 64'd1);
      check("run_ready", 64'(b.resp_ready), 64'(len != 0));
      for (int i = 0; i < nv && acc < len; i++) begin
         check("compact_ready", 64'(b.resp_ready), 64'd1);
         b.resp_valid = valid_a[i];
         b.resp_data = valid_a[i] ? data_a[acc] : {$urandom, $urandom};
         @(negedge clk);
         if (valid_a[i]) begin
            s = step(s, data_a[acc]);
            acc++;
         end
      end
      b.resp_valid = 1'b0;
      check("beats", 64'(acc), 64'(len));
      sb.push_back('{s, s == expv});
      check("check_ready", 64'(b.resp_ready), 64'd0);
      check("check_busy", 64'(b.busy), 64'd1);
      check("check_done", 64'(b.done), 64'd0);
      @(negedge clk);
      check("done_pulse", 64'(b.done), 64'd1);
      check("done_idle", 64'(b.busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      b.start = 1'b0;
      b.abort = 1'b0;
      b.length = '0;
      b.expected = '0;
      b.resp_valid = 1'b0;
      b.resp_data = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(b.busy), 64'd0);
      check("rst_ready", 64'(b.resp_ready), 64'd0);
      check("rst_done", 64'(b.done), 64'd0);
      check("rst_pass", 64'(b.pass), 64'd0);
      check("rst_sig", b.signature, 64'd1);
      rst_n = 1'b1;
      @(negedge clk);
      // length 0, start and abort together: start wins
      run(0, 64'h1, 0, 1'b0, 1'b1);
      check("len0_sig", b.signature, 64'd1);
      @(negedge clk);
      check("pass_held", 64'(b.pass), 64'd1);
      check("done_one_cycle", 64'(b.done), 64'd0);
      // single beat of zero and of one
      data_a[0] = 64'd0;
      valid_a[0] = 1'b1;
      run(1, ONE_BEAT0, 1, 1'b0, 1'b0);
      check("len1_sig0", b.signature, ONE_BEAT0);
      @(negedge clk);
      data_a[0] = 64'd1;
      run(1, ONE_BEAT0, 1, 1'b0, 1'b0);
      check("len1_sig1", b.signature, 64'h8010_0810_0810_2041);
      @(negedge clk);
      check("len1_fail_held", 64'(b.pass), 64'd0);
      // gapped stream of four beats
      valid_a[0:6] = '{1, 0, 0, 1, 1, 0, 1};
      m = 64'd1;
      for (int i = 0; i < 4; i++) begin
         data_a[i] = {$urandom, $urandom};
         m = step(m, data_a[i]);
      end
      run(4, m, 7, 1'b0, 1'b0);
      check("len4_sig", b.signature, m);
      @(negedge clk);
      check("len4_pass", 64'(b.pass), 64'd1);
      // abort alongside the 2nd of 3 beats
      b.start = 1'b1;
      b.length = 16'd3;
      b.expected = '0;
      @(negedge clk);
      b.start = 1'b0;
      b.resp_valid = 1'b1;
      b.resp_data = data_a[0];
      @(negedge clk);
      b.resp_data = data_a[1];
      b.abort = 1'b1;
      @(negedge clk);
      b.abort = 1'b0;
      b.resp_valid = 1'b0;
      check("abort_busy", 64'(b.busy), 64'd0);
      check("abort_pass", 64'(b.pass), 64'd0);
      check("abort_sig", b.signature, step(64'd1, data_a[0]));
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", 64'(b.done), 64'd0);
      end
      // asynchronous reset in the middle of a run
      b.start = 1'b1;
      b.length = 16'd3;
      @(negedge clk);
      b.start = 1'b0;
      b.resp_valid = 1'b1;
      b.resp_data = data_a[2];
      @(negedge clk);
      b.resp_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(b.busy), 64'd0);
      check("arst_ready", 64'(b.resp_ready), 64'd0);
      check("arst_done", 64'(b.done), 64'd0);
      check("arst_sig", b.signature, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      data_a[0] = 64'd0;
      valid_a[0] = 1'b1;
      run(1, ONE_BEAT0, 1, 1'b0, 1'b0);
      // start held through a run, then relaunched in the done cycle
      @(negedge clk);
      valid_a[0:1] = '{1, 1};
      data_a[0] = {$urandom, $urandom};
      data_a[1] = {$urandom, $urandom};
      m = step(step(64'd1, data_a[0]), data_a[1]);
      run(2, m, 2, 1'b1, 1'b0);
      m = step(64'd1, data_a[0]);
      run(1, m, 1, 1'b0, 1'b0);
      check("chain_sig", b.signature, m);
      repeat (2) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
